// File: rtl/npn_tt_sweep_ctrl.sv
// Truth-table sweep sequencer for one 4-input/1-output combinational netlist.
// Drives all 16 input vectors, with an optional input/output phase flip.
// Each vector is held for SETTLE cycles and the netlist output is sampled on the last one.
// The captured table is compared against an expected table.
module npn_tt_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_tt,
  input  logic [3:0]  neg_in,
  input  logic        neg_out,
  output logic [3:0]  x_out,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt_out,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_fail,
  output logic        fail_vld
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] exp_l, exp_l_n;
  logic [3:0]  neg_in_l, neg_in_l_n;
  logic        neg_out_l, neg_out_l_n;
  logic [3:0]  x_out_n;
  logic        busy_n, done_n, pass_n, fail_vld_n;
  logic [15:0] tt_out_n;
  logic [4:0]  err_cnt_n;
  logic [3:0]  first_fail_n;
  logic        cap, mism;

  // The phase-corrected sample and whether it disagrees with the expected bit for the current vector
  always_comb begin
    cap  = y_in ^ neg_out_l;
    mism = cap ^ exp_l[idx];
  end

  // Next-state and next-output logic: sweep sequencing, capture and error bookkeeping
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    exp_l_n      = exp_l;
    neg_in_l_n   = neg_in_l;
    neg_out_l_n  = neg_out_l;
    x_out_n      = x_out;
    busy_n       = busy;
    done_n       = 1'b0;
    pass_n       = pass;
    tt_out_n     = tt_out;
    err_cnt_n    = err_cnt;
    first_fail_n = first_fail;
    fail_vld_n   = fail_vld;

    case (state)
      IDLE: begin
        x_out_n = 4'd0;
        if (start) begin
          exp_l_n      = exp_tt;
          neg_in_l_n   = neg_in;
          neg_out_l_n  = neg_out;
          tt_out_n     = 16'd0;
          err_cnt_n    = 5'd0;
          first_fail_n = 4'd0;
          fail_vld_n   = 1'b0;
          pass_n       = 1'b0;
          idx_n        = 4'd0;
          cnt_n        = 4'd0;
          x_out_n      = neg_in;
          busy_n       = 1'b1;
          state_n      = DRIVE;
        end
      end

      DRIVE: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          x_out_n = 4'd0;
          pass_n  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          tt_out_n[idx] = cap;
          if (mism) begin
            err_cnt_n = err_cnt + 5'd1;
            if (!fail_vld) begin
              first_fail_n = idx;
              fail_vld_n   = 1'b1;
            end
          end
          if (idx == 4'd15) begin
            state_n = DONE;
            busy_n  = 1'b0;
            x_out_n = 4'd0;
            done_n  = 1'b1;
            pass_n  = (err_cnt_n == 5'd0);
          end else begin
            idx_n   = idx + 4'd1;
            cnt_n   = 4'd0;
            x_out_n = (idx + 4'd1) ^ neg_in_l;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= 4'd0;
      exp_l      <= 16'd0;
      neg_in_l   <= 4'd0;
      neg_out_l  <= 1'b0;
      x_out      <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      tt_out     <= 16'd0;
      err_cnt    <= 5'd0;
      first_fail <= 4'd0;
      fail_vld   <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      exp_l      <= exp_l_n;
      neg_in_l   <= neg_in_l_n;
      neg_out_l  <= neg_out_l_n;
      x_out      <= x_out_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      tt_out     <= tt_out_n;
      err_cnt    <= err_cnt_n;
      first_fail <= first_fail_n;
      fail_vld   <= fail_vld_n;
    end
  end

endmodule

// File: tb/tb_npn_tt_sweep_ctrl.sv
// Bench for npn_tt_sweep_ctrl: an AND/XOR netlist model on the DUT's vector bus.
// A cycle-count model of the sweep is checked against the DUT every cycle.
// Directed sweeps are checked against hand-computed results.
module tb_npn_tt_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int SW     = 16 * SETTLE;

  logic        clk = 1'b0;
  logic        rst, start, abort, neg_out, y_in;
  logic [15:0] exp_tt, tt_out;
  logic [3:0]  neg_in, x_out, first_fail;
  logic [4:0]  err_cnt;
  logic        busy, done, pass, fail_vld;
  logic        net_xor;

  int checks = 0;
  int errors = 0;

  npn_tt_sweep_ctrl #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .exp_tt(exp_tt), .neg_in(neg_in), .neg_out(neg_out),
    .x_out(x_out), .y_in(y_in), .busy(busy), .done(done), .pass(pass),
    .tt_out(tt_out), .err_cnt(err_cnt), .first_fail(first_fail), .fail_vld(fail_vld)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Netlist under test: 4-input AND or 4-input XOR
  assign y_in = net_xor ? ^x_out : &x_out;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] full_tt(input logic xr, input logic [3:0] nin, input logic nout);
    logic [15:0] t;
    logic [3:0]  v;
    t = 16'd0;
    for (int i = 0; i < 16; i++) begin
      v    = 4'(i) ^ nin;
      t[i] = (xr ? ^v : &v) ^ nout;
    end
    return t;
  endfunction

  // Model state: m_k counts cycles since start accept (-1 when idle), m_s counts vectors sampled
  int          m_k = -1;
  int          m_s = 0;
  bit          m_valid = 0, m_complete = 0, m_unknown = 0;
  logic [15:0] m_exp = 0, m_full = 0;
  logic [3:0]  m_nin = 0;

  // Abstract sweep model advanced on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_k = -1; m_s = 0; m_complete = 0; m_unknown = 0;
      m_exp = 0; m_full = 0; m_nin = 0;
    end else if (m_valid) begin
      if (m_k < 0) begin
        if (start) begin
          m_k = 0; m_s = 0; m_complete = 0; m_unknown = 0;
          m_exp = exp_tt; m_nin = neg_in;
          m_full = full_tt(net_xor, neg_in, neg_out);
        end
      end else if (m_k < SW && abort) begin
        m_k = -1; m_unknown = 1;
      end else begin
        m_k++;
        if (m_k <= SW) m_s = m_k / SETTLE;
        if (m_k == SW) m_complete = 1;
        if (m_k > SW) m_k = -1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    logic [15:0] mask, mism;
    int          ec, ff;
    logic        eb;
    if (m_valid) begin
      mask = 16'((32'd1 << m_s) - 1);
      mism = (m_full ^ m_exp) & mask;
      ec   = $countones(mism);
      ff   = 0;
      for (int i = 15; i >= 0; i--) if (mism[i]) ff = i;
      eb = (m_k >= 0) && (m_k < SW);
      checkOutput("busy", 32'(busy), 32'(eb));
      checkOutput("x_out", 32'(x_out), eb ? 32'(4'(m_k / SETTLE) ^ m_nin) : 32'd0);
      checkOutput("done", 32'(done), 32'(m_k == SW));
      checkOutput("pass", 32'(pass), 32'(m_complete && ec == 0));
      if (!m_unknown) begin
        checkOutput("tt_out", 32'(tt_out), 32'(m_full & mask));
        checkOutput("err_cnt", 32'(err_cnt), 32'(ec));
        checkOutput("fail_vld", 32'(fail_vld), 32'(mism != 16'd0));
        checkOutput("first_fail", 32'(first_fail), 32'(ff));
      end
    end
  end

  int          bc;
  bit          gd;
  logic [3:0]  fx, lx;

  // One sweep: start pulse, then watch busy/done with a bounded wait, optionally injecting abort/rst/start
  task automatic applyStimulus(input logic xr, input logic [15:0] e, input logic [3:0] nin,
                               input logic nout, input int abort_at, input int rst_at,
                               input bit poke, output int busy_cycles, output bit got_done,
                               output logic [3:0] first_x, output logic [3:0] last_x);
    net_xor = xr; exp_tt = e; neg_in = nin; neg_out = nout; start = 1'b1;
    @(negedge clk);
    start = 1'b0; exp_tt = ~e; neg_in = ~nin; neg_out = ~nout;
    busy_cycles = 0; got_done = 0; first_x = 4'd0; last_x = 4'd0;
    for (int c = 0; c < SW + 10 && !got_done; c++) begin
      if (busy) begin
        if (busy_cycles == 0) first_x = x_out;
        last_x = x_out;
        busy_cycles++;
      end
      if (done) got_done = 1;
      start = poke && ((busy && (busy_cycles == 5 || busy_cycles == SW)) || done);
      abort = (abort_at > 0) && busy && (busy_cycles == abort_at);
      rst   = (rst_at > 0) && busy && (busy_cycles == rst_at);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    if (abort_at == 0 && rst_at == 0) checkOutput("done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; exp_tt = 16'd0; neg_in = 4'd0;
    neg_out = 1'b0; net_xor = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tt", 32'(tt_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] sweep 1: AND, exp 8000");
    applyStimulus(1'b0, 16'h8000, 4'h0, 1'b0, 0, 0, 0, bc, gd, fx, lx);
    checkOutput("t1_busy_len", 32'(bc), 32'd32);
    checkOutput("t1_tt", 32'(tt_out), 32'h8000);
    checkOutput("t1_pass", 32'(pass), 32'd1);
    checkOutput("t1_err", 32'(err_cnt), 32'd0);
    checkOutput("t1_fv", 32'(fail_vld), 32'd0);

    $display("[TB] sweep 2: XOR, neg_out");
    applyStimulus(1'b1, 16'h6996, 4'h0, 1'b1, 0, 0, 0, bc, gd, fx, lx);
    checkOutput("t2_tt", 32'(tt_out), 32'h9669);
    checkOutput("t2_err", 32'(err_cnt), 32'd16);
    checkOutput("t2_ff", 32'(first_fail), 32'd0);
    checkOutput("t2_fv", 32'(fail_vld), 32'd1);
    checkOutput("t2_pass", 32'(pass), 32'd0);

    $display("[TB] sweep 3: AND, neg_in F");
    applyStimulus(1'b0, 16'h0001, 4'hF, 1'b0, 0, 0, 0, bc, gd, fx, lx);
    checkOutput("t3_first_x", 32'(fx), 32'hF);
    checkOutput("t3_last_x", 32'(lx), 32'h0);
    checkOutput("t3_tt", 32'(tt_out), 32'h0001);
    checkOutput("t3_pass", 32'(pass), 32'd1);

    $display("[TB] sweep 4: AND, exp C000");
    applyStimulus(1'b0, 16'hC000, 4'h0, 1'b0, 0, 0, 0, bc, gd, fx, lx);
    checkOutput("t4_err", 32'(err_cnt), 32'd1);
    checkOutput("t4_ff", 32'(first_fail), 32'd14);
    checkOutput("t4_fv", 32'(fail_vld), 32'd1);
    checkOutput("t4_pass", 32'(pass), 32'd0);

    $display("[TB] sweep 5: abort, then start pokes while busy");
    applyStimulus(1'b0, 16'h8000, 4'h0, 1'b0, 10, 0, 0, bc, gd, fx, lx);
    checkOutput("t5_busy_len", 32'(bc), 32'd10);
    checkOutput("t5_no_done", 32'(gd), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_x", 32'(x_out), 32'd0);
    checkOutput("t5_pass", 32'(pass), 32'd0);
    applyStimulus(1'b0, 16'h8000, 4'h0, 1'b0, 0, 0, 1, bc, gd, fx, lx);
    checkOutput("t5b_busy_len", 32'(bc), 32'd32);
    repeat (3) @(negedge clk);
    checkOutput("t5b_idle", 32'(busy), 32'd0);
    checkOutput("t5b_tt", 32'(tt_out), 32'h8000);
    checkOutput("t5b_pass", 32'(pass), 32'd1);

    $display("[TB] sweep 6: reset mid-sweep");
    applyStimulus(1'b0, 16'h8000, 4'h0, 1'b0, 0, 15, 0, bc, gd, fx, lx);
    checkOutput("t6_busy_len", 32'(bc), 32'd15);
    checkOutput("t6_no_done", 32'(gd), 32'd0);
    checkOutput("t6_tt", 32'(tt_out), 32'd0);
    checkOutput("t6_err", 32'(err_cnt), 32'd0);
    checkOutput("t6_x", 32'(x_out), 32'd0);
    applyStimulus(1'b0, 16'h8000, 4'h0, 1'b0, 0, 0, 0, bc, gd, fx, lx);
    checkOutput("t6b_busy_len", 32'(bc), 32'd32);
    checkOutput("t6b_tt", 32'(tt_out), 32'h8000);
    checkOutput("t6b_pass", 32'(pass), 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
